// File: rtl/play_ctrl.sv
// play_ctrl: fixed-priority arbiter for playback commands with decoder load/volume handshakes
module play_ctrl #(
  parameter int         SONG_NUM = 2,
  parameter logic [7:0] VOL_STEP = 8'd14,
  parameter logic [7:0] VOL_MAX  = 8'hFC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_bt_valid,
  input  logic [7:0]  i_bt_cmd,
  input  logic [4:0]  i_key,
  input  logic        i_finish,
  input  logic        i_load_ack,
  input  logic        i_vol_wr_ack,
  output logic [4:0]  o_song,
  output logic        o_pause,
  output logic [15:0] o_vol,
  output logic        o_load_req,
  output logic        o_vol_wr_req,
  output logic        o_busy
);
  typedef enum logic [1:0] {IDLE, EXEC, LOAD, VOLW} state_t;
  typedef enum logic [2:0] {C_NONE, C_PAUSE, C_NEXT, C_PREV, C_UP, C_DOWN, C_SEL} cmd_t;
  localparam logic [5:0] SN   = 6'(SONG_NUM);
  localparam logic [4:0] LAST = 5'(SONG_NUM - 1);
  state_t      state;
  cmd_t        cmd, bt_dec, key_dec, bt_c, key_c;
  logic [4:0]  idx, bt_n, new_song;
  logic        fin_v, bt_v, key_v, song_chg, idle;
  logic [15:0] new_vol;
  function automatic logic [7:0] vol_up(input logic [7:0] b);
    return b >= VOL_STEP ? b - VOL_STEP : 8'd0;
  endfunction
  function automatic logic [7:0] vol_dn(input logic [7:0] b);
    return b <= VOL_MAX - VOL_STEP ? b + VOL_STEP : VOL_MAX;
  endfunction
  // decode incoming events and work out what the latched command would do
  always_comb begin
    bt_dec = i_bt_cmd == 8'h01 ? C_PAUSE :
             i_bt_cmd == 8'h02 ? C_NEXT :
             i_bt_cmd == 8'h03 ? C_PREV :
             i_bt_cmd == 8'h04 ? C_UP :
             i_bt_cmd == 8'h05 ? C_DOWN :
             (i_bt_cmd[7:5] == 3'b010 && {1'b0, i_bt_cmd[4:0]} < SN) ? C_SEL : C_NONE;
    key_dec = i_key[0] ? C_PAUSE : i_key[1] ? C_NEXT : i_key[2] ? C_PREV :
              i_key[3] ? C_UP : i_key[4] ? C_DOWN : C_NONE;
    idle = state == IDLE;
    song_chg = cmd == C_NEXT || cmd == C_PREV || cmd == C_SEL;
    new_song = cmd == C_NEXT ? (o_song == LAST ? 5'd0 : o_song + 5'd1) :
               cmd == C_PREV ? (o_song == 5'd0 ? LAST : o_song - 5'd1) :
               cmd == C_SEL  ? idx : o_song;
    new_vol = cmd == C_UP   ? {vol_up(o_vol[15:8]), vol_up(o_vol[7:0])} :
              cmd == C_DOWN ? {vol_dn(o_vol[15:8]), vol_dn(o_vol[7:0])} : o_vol;
  end
  // pending slots: a fresh event from a source overrides a same-cycle grant of that source
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_v <= 1'b0;
      bt_v  <= 1'b0;
      bt_c  <= C_NONE;
      bt_n  <= 5'd0;
      key_v <= 1'b0;
      key_c <= C_NONE;
    end else begin
      fin_v <= i_finish | (fin_v & ~idle);
      if (i_bt_valid && bt_dec != C_NONE) begin
        bt_v <= 1'b1;
        bt_c <= bt_dec;
        bt_n <= i_bt_cmd[4:0];
      end else if (idle && !fin_v) bt_v <= 1'b0;
      if (key_dec != C_NONE) begin
        key_v <= 1'b1;
        key_c <= key_dec;
      end else if (idle && !fin_v && !bt_v) key_v <= 1'b0;
    end
  end
  // command FSM: grant, execute for one cycle, then hold a request until acknowledged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      cmd          <= C_NONE;
      idx          <= 5'd0;
      o_song       <= 5'd0;
      o_pause      <= 1'b0;
      o_vol        <= 16'h0000;
      o_load_req   <= 1'b0;
      o_vol_wr_req <= 1'b0;
    end else begin
      case (state)
        IDLE: if (fin_v || bt_v || key_v) begin
          cmd   <= fin_v ? C_NEXT : bt_v ? bt_c : key_c;
          idx   <= bt_n;
          state <= EXEC;
        end
        EXEC: begin
          o_song       <= new_song;
          o_vol        <= new_vol;
          o_pause      <= song_chg ? 1'b0 : cmd == C_PAUSE ? ~o_pause : o_pause;
          o_load_req   <= song_chg;
          o_vol_wr_req <= new_vol != o_vol;
          state        <= song_chg ? LOAD : new_vol != o_vol ? VOLW : IDLE;
        end
        LOAD: if (i_load_ack) begin
          o_load_req <= 1'b0;
          state      <= IDLE;
        end
        VOLW: if (i_vol_wr_ack) begin
          o_vol_wr_req <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  assign o_busy = state != IDLE;
endmodule

// File: tb/tb_play_ctrl.sv
// tb_play_ctrl: randomized scoreboard bench for play_ctrl against a command-level model
module tb_play_ctrl;
  localparam int SN   = 2;
  localparam int STEP = 14;
  localparam int VMAX = 252;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        i_bt_valid = 1'b0, i_finish = 1'b0, i_load_ack = 1'b0, i_vol_wr_ack = 1'b0;
  logic [7:0]  i_bt_cmd = 8'h00;
  logic [4:0]  i_key = 5'd0;
  logic [4:0]  o_song;
  logic        o_pause, o_load_req, o_vol_wr_req, o_busy;
  logic [15:0] o_vol;
  typedef struct packed {logic [4:0] song; logic pause; logic [15:0] vol; logic lreq; logic vreq;} exp_t;
  typedef struct {bit fin; bit btv; logic [7:0] btc; logic [4:0] key;} ev_t;
  exp_t exq[$];
  int   vectors = 0, miscompares = 0;
  int   m_song = 0, m_pause = 0, m_vl = 0, m_vr = 0;
  bit   p_fin, p_bt, p_key;
  int   p_bt_cmd, p_key_cmd;
  bit   ack_en = 1'b1;
  play_ctrl dut (
    .clk(clk), .rst_n(rst_n), .i_bt_valid(i_bt_valid), .i_bt_cmd(i_bt_cmd), .i_key(i_key),
    .i_finish(i_finish), .i_load_ack(i_load_ack), .i_vol_wr_ack(i_vol_wr_ack), .o_song(o_song),
    .o_pause(o_pause), .o_vol(o_vol), .o_load_req(o_load_req), .o_vol_wr_req(o_vol_wr_req), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction
  function automatic void fail(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s (t=%0t)", name, $time);
  endfunction
  function automatic bit legal(int b);
    return (b >= 1 && b <= 5) || (b >= 64 && b < 64 + SN);
  endfunction
  function automatic int key_code(logic [4:0] k);
    for (int i = 0; i < 5; i++) if (k[i]) return i + 1;
    return 0;
  endfunction
  function automatic ev_t mk(bit fin, bit btv, logic [7:0] btc, logic [4:0] key);
    ev_t e;
    e.fin = fin; e.btv = btv; e.btc = btc; e.key = key;
    return e;
  endfunction
  // apply one command (bt byte coding) to the model; push its visible outcome; return handshake flag
  function automatic bit apply(int c);
    exp_t e;
    int nl = m_vl, nr = m_vr;
    bit song_chg = (c == 2 || c == 3 || c >= 64);
    if (c == 1) m_pause = 1 - m_pause;
    if (c == 2) m_song = (m_song + 1) % SN;
    if (c == 3) m_song = (m_song + SN - 1) % SN;
    if (c >= 64) m_song = c - 64;
    if (song_chg) m_pause = 0;
    if (c == 4) begin nl = m_vl - STEP; nr = m_vr - STEP; if (nl < 0) nl = 0; if (nr < 0) nr = 0; end
    if (c == 5) begin nl = m_vl + STEP; nr = m_vr + STEP; if (nl > VMAX) nl = VMAX; if (nr > VMAX) nr = VMAX; end
    e.vreq = (nl != m_vl) || (nr != m_vr);
    m_vl = nl; m_vr = nr;
    e.song = 5'(m_song); e.pause = m_pause[0]; e.vol = {8'(m_vl), 8'(m_vr)}; e.lreq = song_chg;
    exq.push_back(e);
    return e.lreq | e.vreq;
  endfunction
  function automatic void add_events(ev_t e);
    if (e.fin) p_fin = 1;
    if (e.btv && legal(int'(e.btc))) begin p_bt = 1; p_bt_cmd = int'(e.btc); end
    if (key_code(e.key) != 0) begin p_key = 1; p_key_cmd = key_code(e.key); end
  endfunction
  function automatic bit serve_one();
    if (p_fin) begin p_fin = 0; return apply(2); end
    if (p_bt) begin p_bt = 0; return apply(p_bt_cmd); end
    if (p_key) begin p_key = 0; return apply(p_key_cmd); end
    return 0;
  endfunction
  function automatic void serve_rest();
    bit h;
    while (p_fin || p_bt || p_key) h = serve_one();
  endfunction
  task automatic drive(ev_t e);
    i_finish = e.fin; i_bt_valid = e.btv; i_bt_cmd = e.btc; i_key = e.key;
    @(negedge clk);
    i_finish = 1'b0; i_bt_valid = 1'b0; i_key = 5'd0;
  endtask
  task automatic wait_req(output bit ok);
    int t = 0;
    while (!(o_load_req || o_vol_wr_req) && t < 20) begin @(negedge clk); t++; end
    ok = t < 20;
    if (!ok) fail("request_timeout");
  endtask
  task automatic drain();
    int t = 0;
    while ((exq.size() != 0 || o_busy) && t < 400) begin @(negedge clk); t++; end
    if (t >= 400) begin fail("drain_timeout"); exq.delete(); end
    repeat (2) @(negedge clk);
  endtask
  // one cycle of simultaneous events; optionally two more cycles of events while the first request waits
  task automatic burst(ev_t e0, bit late, ev_t l1, ev_t l2);
    bit hs, ok;
    add_events(e0);
    hs = serve_one();
    if (!(hs && late)) serve_rest();
    drive(e0);
    if (hs && late) begin
      add_events(l1);
      add_events(l2);
      serve_rest();
      wait_req(ok);
      if (ok) begin drive(l1); drive(l2); end
    end
    drain();
  endtask
  function automatic logic [7:0] rnd_bt();
    logic [7:0] pick [7];
    pick = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h40, 8'h41};
    return $urandom_range(0, 3) == 0 ? 8'($urandom_range(0, 255)) : pick[$urandom_range(0, 6)];
  endfunction
  function automatic ev_t rnd_ev();
    return mk($urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, rnd_bt(),
              $urandom_range(0, 2) == 0 ? 5'($urandom_range(1, 31)) : 5'd0);
  endfunction
  // monitor: a rising o_busy marks an EXEC cycle; the next sample shows that command's outcome
  initial begin
    bit pb, ck;
    exp_t e;
    pb = 0; ck = 0;
    forever @(negedge clk) begin
      if (!rst_n) begin pb = 0; ck = 0; end
      else begin
        if (ck) begin
          ck = 0;
          if (exq.size() == 0) fail("unexpected_command");
          else begin
            e = exq.pop_front();
            chk("song", int'(o_song), int'(e.song));
            chk("pause", int'(o_pause), int'(e.pause));
            chk("vol", int'(o_vol), int'(e.vol));
            chk("load_req", int'(o_load_req), int'(e.lreq));
            chk("vol_wr_req", int'(o_vol_wr_req), int'(e.vreq));
          end
        end
        if (o_busy && !pb) ck = 1;
        pb = o_busy;
      end
    end
  end
  // feeder/decoder responder: acks after a random wait, and sometimes acks with no request pending
  initial begin
    int cnt, d;
    cnt = 0; d = 3;
    forever @(negedge clk) begin
      i_load_ack = 1'b0; i_vol_wr_ack = 1'b0;
      if (ack_en && rst_n) begin
        if (o_load_req || o_vol_wr_req) begin
          cnt++;
          if (cnt >= d) begin
            i_load_ack = o_load_req; i_vol_wr_ack = o_vol_wr_req;
            cnt = 0; d = $urandom_range(3, 7);
          end
        end else begin
          cnt = 0;
          i_load_ack = $urandom_range(0, 5) == 0;
          i_vol_wr_ack = $urandom_range(0, 5) == 0;
        end
      end
    end
  end
  // main stimulus sequence
  initial begin
    ev_t none, e;
    bit ok;
    none = mk(0, 0, 8'h00, 5'd0);
    repeat (2) @(negedge clk);
    chk("rst_song", int'(o_song), 0);
    chk("rst_pause", int'(o_pause), 0);
    chk("rst_vol", int'(o_vol), 0);
    chk("rst_load_req", int'(o_load_req), 0);
    chk("rst_vol_wr_req", int'(o_vol_wr_req), 0);
    chk("rst_busy", int'(o_busy), 0);
    rst_n = 1'b1;
    @(negedge clk);
    burst(mk(0, 1, 8'h02, 5'd0), 0, none, none);
    burst(mk(1, 0, 8'h00, 5'd0), 0, none, none);
    burst(mk(0, 0, 8'h00, 5'b00100), 0, none, none);
    burst(mk(0, 1, 8'h04, 5'd0), 0, none, none);
    for (int i = 0; i < 19; i++) burst(mk(0, i[0], 8'h05, i[0] ? 5'd0 : 5'b10000), 0, none, none);
    chk("vol_capped", int'(o_vol), 16'hFCFC);
    burst(mk(1, 1, 8'h04, 5'b00001), 0, none, none);
    burst(mk(0, 1, 8'h02, 5'd0), 1, mk(0, 1, 8'h01, 5'd0), mk(0, 1, 8'h05, 5'b00010));
    burst(mk(0, 1, 8'h41, 5'd0), 0, none, none);
    burst(mk(0, 1, 8'h42, 5'd0), 0, none, none);
    burst(mk(0, 1, 8'h07, 5'd0), 0, none, none);
    chk("ignored_busy", int'(o_busy), 0);
    for (int i = 0; i < 150; i++) burst(rnd_ev(), $urandom_range(0, 1) == 1, rnd_ev(), rnd_ev());
    ack_en = 1'b0;
    add_events(mk(1, 1, 8'h04, 5'b00001));
    ok = serve_one();
    drive(mk(1, 1, 8'h04, 5'b00001));
    wait_req(ok);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_song", int'(o_song), 0);
    chk("arst_pause", int'(o_pause), 0);
    chk("arst_vol", int'(o_vol), 0);
    chk("arst_load_req", int'(o_load_req), 0);
    chk("arst_vol_wr_req", int'(o_vol_wr_req), 0);
    chk("arst_busy", int'(o_busy), 0);
    m_song = 0; m_pause = 0; m_vl = 0; m_vr = 0;
    p_fin = 0; p_bt = 0; p_key = 0;
    exq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", int'(o_busy), 0);
    burst(mk(0, 1, 8'h02, 5'b01000), 0, none, none);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
